// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
// Package : fpu_pkg
// Brief   : Shared binary32 types and constants for the FPU datapath blocks.
// Rev     : 1.0
// ============================================================================
package fpu_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
    } fp32_t;

    localparam int         EXP_BIAS = 127;
    localparam logic [7:0] EXP_INF  = 8'hFF;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        INV  = 3'd1,
        MUL  = 3'd2,
        RND  = 3'd3,
        DONE = 3'd4
    } fdiv_state_t;

endpackage
`default_nettype wire

// File: rtl/finv.sv
`default_nettype none
// ============================================================================
// Module : finv
// Brief  : Combinational binary32 reciprocal, round-to-nearest-even, flushes
//          zero/denormal inputs to infinity and tiny results to zero.
// Rev    : 1.0
// ============================================================================
module finv
    import fpu_pkg::*;
(
    input  logic [31:0] x,
    output logic [31:0] y
);

    localparam logic [49:0] NUM = 50'd1 << 49;

    logic [49:0]       den;
    logic [24:0]       q;
    logic              sticky;
    logic              rnd_up;
    logic [22:0]       mr;
    logic signed [9:0] re;

    always_comb begin
        den    = {26'd0, 1'b1, x[22:0]};
        // Leading quotient bit (bit 25) is always 1 for a non-unit mantissa
        q      = 25'(NUM / den);
        sticky = |(NUM % den);
        rnd_up = q[1] & (q[0] | sticky | q[2]);
        mr     = q[24:2] + {22'd0, rnd_up};
        re     = 10'sd0;
        y      = {x[31], 31'd0};
        if (x[30:23] == 8'd0) begin
            y = {x[31], EXP_INF, 23'd0};
        end else if (x[30:23] == EXP_INF) begin
            y = {x[31], 31'd0};
        end else if (x[22:0] == 23'd0) begin
            re = 10'sd254 - $signed({2'b00, x[30:23]});
            if (re > 10'sd0) y = {x[31], re[7:0], 23'd0};
        end else begin
            re = 10'sd253 - $signed({2'b00, x[30:23]});
            if (re > 10'sd0) y = {x[31], re[7:0], mr};
        end
    end

endmodule
`default_nettype wire

// File: rtl/fmul_round.sv
`default_nettype none
// ============================================================================
// Module : fmul_round
// Brief  : Normalize, round-to-nearest-even and pack a 48-bit mantissa product.
// Rev    : 1.0
// ============================================================================
module fmul_round
    import fpu_pkg::*;
(
    input  logic              sign,
    input  logic [47:0]       prod,
    input  logic signed [9:0] exp_in,
    output logic [31:0]       y,
    output logic              ovf,
    output logic              udf
);

    logic [22:0]       mant;
    logic              guard;
    logic              rbit;
    logic              sticky;
    logic              up;
    logic [23:0]       mant_rnd;
    logic signed [9:0] e;

    always_comb begin
        if (prod[47]) begin
            mant   = prod[46:24];
            guard  = prod[23];
            rbit   = prod[22];
            sticky = |prod[21:0];
            e      = exp_in + 10'sd1;
        end else begin
            mant   = prod[45:23];
            guard  = prod[22];
            rbit   = prod[21];
            sticky = |prod[20:0];
            e      = exp_in;
        end
        up       = guard & (rbit | sticky | mant[0]);
        mant_rnd = {1'b0, mant} + {23'd0, up};
        // A carry out leaves the stored mantissa at zero: 1.11..1 + ulp = 10.0
        if (mant_rnd[23]) e = e + 10'sd1;

        y   = {sign, e[7:0], mant_rnd[22:0]};
        ovf = 1'b0;
        udf = 1'b0;
        if (e >= 10'sd255) begin
            y   = {sign, EXP_INF, 23'd0};
            ovf = 1'b1;
        end else if (e <= 10'sd0) begin
            y   = {sign, 31'd0};
            udf = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fdiv_seq.sv
`default_nettype none
// ============================================================================
// Module : fdiv_seq
// Brief  : Multi-cycle binary32 divider computing x1 * finv(x2), one op in flight.
// Rev    : 1.0
// ============================================================================
module fdiv_seq
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y,
    output logic        ovf,
    output logic        udf
);

    fdiv_state_t state, state_next;

    fp32_t             a_q;
    logic [31:0]       b_q;
    fp32_t             recip_q;
    logic              inf_q;
    logic              zero_q;
    logic              tiny_q;
    logic [47:0]       prod_q;
    logic signed [9:0] exp_q;
    logic              sign_q;

    logic [31:0] recip_w;
    logic [31:0] rnd_y;
    logic        rnd_ovf;
    logic        rnd_udf;

    finv u_finv (
        .x (b_q),
        .y (recip_w)
    );

    fmul_round u_round (
        .sign   (sign_q),
        .prod   (prod_q),
        .exp_in (exp_q),
        .y      (rnd_y),
        .ovf    (rnd_ovf),
        .udf    (rnd_udf)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = INV;
            end
            INV:  state_next = MUL;
            MUL:  state_next = RND;
            RND:  state_next = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            recip_q <= '0;
            inf_q   <= 1'b0;
            zero_q  <= 1'b0;
            tiny_q  <= 1'b0;
            prod_q  <= '0;
            exp_q   <= '0;
            sign_q  <= 1'b0;
            y       <= '0;
            ovf     <= 1'b0;
            udf     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q <= x1;
                        b_q <= x2;
                    end
                end
                INV: begin
                    recip_q <= recip_w;
                    inf_q   <= (b_q[30:23] == 8'd0);
                    zero_q  <= (a_q.exp == 8'd0);
                    tiny_q  <= (recip_w[30:23] == 8'd0);
                end
                MUL: begin
                    prod_q <= 48'({1'b1, a_q.mant}) * 48'({1'b1, recip_q.mant});
                    exp_q  <= $signed({2'b00, a_q.exp}) - 10'(EXP_BIAS)
                              + $signed({2'b00, recip_q.exp});
                    // finv preserves sign, so this equals x1.sign ^ x2.sign
                    sign_q <= a_q.sign ^ recip_q.sign;
                end
                RND: begin
                    if (inf_q) begin
                        y   <= {sign_q, EXP_INF, 23'd0};
                        ovf <= 1'b1;
                        udf <= 1'b0;
                    end else if (zero_q) begin
                        y   <= {sign_q, 31'd0};
                        ovf <= 1'b0;
                        udf <= 1'b0;
                    end else if (tiny_q) begin
                        y   <= {sign_q, 31'd0};
                        ovf <= 1'b0;
                        udf <= 1'b1;
                    end else begin
                        y   <= rnd_y;
                        ovf <= rnd_ovf;
                        udf <= rnd_udf;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fdiv_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_fdiv_seq
// Brief  : Self-checking bench for fdiv_seq against an arithmetic reference.
// Rev    : 1.0
// ============================================================================
module tb_fdiv_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x1;
    logic [31:0] x2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;
    logic        ovf;
    logic        udf;

    int tests = 0;
    int fails = 0;

    fdiv_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x1        (x1),
        .x2        (x2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .ovf       (ovf),
        .udf       (udf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Correctly rounded reciprocal; tiny results flush to zero
    function automatic logic [31:0] ref_recip(input logic [31:0] x);
        logic [63:0] m;
        logic [63:0] q;
        int          re;
        if (x[30:23] == 8'd0) return {x[31], 8'hFF, 23'd0};
        m = 64'h800000 + 64'(x[22:0]);
        if (x[22:0] == 23'd0) begin
            re = 254 - int'(x[30:23]);
            q  = 64'h800000;
        end else begin
            re = 253 - int'(x[30:23]);
            q  = (((64'd1 << 48) / m) + 64'd1) >> 1;
        end
        if (re <= 0) return {x[31], 31'd0};
        return {x[31], re[7:0], q[22:0]};
    endfunction

    // Returns {y, ovf, udf}
    function automatic logic [33:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        logic [31:0] r;
        logic [63:0] p, q, rem, half;
        int          e, sh;
        s = a[31] ^ b[31];
        if (b[30:23] == 8'd0) return {s, 8'hFF, 23'd0, 2'b10};
        if (a[30:23] == 8'd0) return {s, 31'd0, 2'b00};
        r = ref_recip(b);
        if (r[30:23] == 8'd0) return {s, 31'd0, 2'b01};
        p  = (64'h800000 + 64'(a[22:0])) * (64'h800000 + 64'(r[22:0]));
        e  = int'(a[30:23]) - 127 + int'(r[30:23]);
        sh = (p >= (64'd1 << 47)) ? 24 : 23;
        e  = e + sh - 23;
        q    = p >> sh;
        rem  = p - (q << sh);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q = q + 64'd1;
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'd0, 2'b10};
        if (e <= 0)   return {s, 31'd0, 2'b01};
        return {s, e[7:0], q[22:0], 2'b00};
    endfunction

    function automatic logic [31:0] rand_fp();
        return {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
    endfunction

    // Wait up to 10 edges for out_valid; returns the edge count seen
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 10) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [33:0] expv);
        int n;
        x1        = a;
        x2        = b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        tick();
        in_valid = 1'b0;
        wait_valid(n);
        chk({tag, "_lat"}, 32'(n), 32'd3);
        chk({tag, "_y"},   y,      expv[33:2]);
        chk({tag, "_ovf"}, 32'(ovf), 32'(expv[1]));
        chk({tag, "_udf"}, 32'(udf), 32'(expv[0]));
        tick();
    endtask

    logic [31:0] dx1 [7] = '{32'h3F800000, 32'h40C00000, 32'hBF800000, 32'hBF800000,
                             32'h7F000000, 32'h00800000, 32'h80000000};
    logic [31:0] dx2 [7] = '{32'h40000000, 32'h40400000, 32'h00000000, 32'h00000001,
                             32'h3E800000, 32'h40000000, 32'h40000000};
    logic [33:0] dex [7] = '{{32'h3F000000, 2'b00}, {32'h40000000, 2'b00},
                             {32'hFF800000, 2'b10}, {32'hFF800000, 2'b10},
                             {32'h7F800000, 2'b10}, {32'h00000000, 2'b01},
                             {32'h80000000, 2'b00}};

    initial begin
        int lat;
        int seen;
        logic [31:0] a, b;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x1        = '0;
        x2        = '0;
        tick();
        tick();
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_y",         y,              32'd0);
        chk("rst_flags",     32'({ovf, udf}), 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            chk($sformatf("model%0d", i), ref_div(dx1[i], dx2[i]) == dex[i] ? 32'd1 : 32'd0, 32'd1);
            run_op($sformatf("dir%0d", i), dx1[i], dx2[i], dex[i]);
        end

        // Backpressure: hold the result, offer a second operand meanwhile
        x1        = 32'h40C00000;
        x2        = 32'h40400000;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        wait_valid(lat);
        chk("bp_lat", 32'(lat), 32'd3);
        x1       = 32'h3F800000;
        x2       = 32'h40000000;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_hold%0d_y", i), y, 32'h40000000);
            chk($sformatf("bp_hold%0d_rdy", i), 32'({in_ready, out_valid}), 32'b01);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("bp_release", 32'({in_ready, out_valid}), 32'b10);
        tick();
        in_valid = 1'b0;
        wait_valid(lat);
        chk("bp_second_lat", 32'(lat), 32'd3);
        chk("bp_second_y",   y,        32'h3F000000);
        tick();

        // Reset while the operation sits in MUL
        x1        = 32'h40C00000;
        x2        = 32'h40400000;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmul_state", 32'({in_ready, out_valid}), 32'b10);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid) seen++;
        end
        chk("rstmul_no_stale", 32'(seen), 32'd0);

        for (int i = 0; i < 200; i++) begin
            a = rand_fp();
            b = rand_fp();
            run_op($sformatf("rnd%0d_%h_%h", i, a, b), a, b, ref_div(a, b));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete within the time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
